// File: rtl/i2c_reg_sequencer_pkg.sv
// Shared types and constants for the I2C register-access sequencer:
// FSM state/phase encodings, resp_err codes, RW constants and the master command set.
package i2c_reg_sequencer_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_A_W,
        ST_REG,
        ST_WDATA,
        ST_RS,
        ST_RELATCH,
        ST_RBYTE,
        ST_STOP,
        ST_DONE
    } state_t;

    // Every bus state runs LOAD (register command) -> HOLD (until tick) -> WAIT (m_done)
    typedef enum logic [1:0] {
        PH_LOAD,
        PH_HOLD,
        PH_WAIT
    } phase_t;

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_NACK    = 2'd1;
    localparam logic [1:0] ERR_LEN     = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    typedef struct packed {
        logic       start;
        logic       stop;
        logic       write;
        logic       read;
        logic       ack_in;
        logic [7:0] data;
    } cmd_t;

    localparam cmd_t CMD_NONE = '0;

    function automatic logic is_bus_state(input state_t s);
        return (s == ST_A_W) || (s == ST_REG) || (s == ST_WDATA) ||
               (s == ST_RS) || (s == ST_RBYTE) || (s == ST_STOP);
    endfunction

endpackage

// File: rtl/i2c_cmd_hold.sv
// Holds a master command set from load until the next tick cycle, and generates the
// single-cycle start+read re-arm pulse, which is only ever emitted in a cycle with tick=0.
module i2c_cmd_hold
    import i2c_reg_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick,
    input  logic       load,
    input  cmd_t       cmd_set,
    input  logic       relatch_load,
    input  logic       clear,
    output logic       hold_done,
    output logic       relatch_fire,
    output logic       m_start,
    output logic       m_stop,
    output logic       m_write,
    output logic       m_read,
    output logic       m_ack_in,
    output logic [7:0] m_data_in
);

    cmd_t cmd_q;
    logic active_q;
    logic relatch_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_q     <= CMD_NONE;
            active_q  <= 1'b0;
            relatch_q <= 1'b0;
        end else if (clear) begin
            cmd_q     <= CMD_NONE;
            active_q  <= 1'b0;
            relatch_q <= 1'b0;
        end else begin
            if (load) begin
                cmd_q    <= cmd_set;
                active_q <= 1'b1;
            end else if (active_q && tick) begin
                cmd_q    <= CMD_NONE;
                active_q <= 1'b0;
            end

            if (relatch_load) begin
                relatch_q <= 1'b1;
            end else if (relatch_fire) begin
                relatch_q <= 1'b0;
            end
        end
    end

    assign hold_done = active_q && tick;

    // A pending re-arm slips past a tick cycle; tick period >= 3 guarantees the next cycle is quiet
    assign relatch_fire = relatch_q && !tick;

    assign m_start   = cmd_q.start || relatch_fire;
    assign m_read    = cmd_q.read || relatch_fire;
    assign m_stop    = cmd_q.stop;
    assign m_write   = cmd_q.write;
    assign m_ack_in  = cmd_q.ack_in;
    assign m_data_in = cmd_q.data;

endmodule

// File: rtl/i2c_reg_sequencer.sv
// Register-access sequencer in front of the byte-level I2C master: one request becomes a full
// write or burst-read transaction. Optional watchdog on m_done enabled by I2C_SEQ_TIMEOUT_EN.
module i2c_reg_sequencer
    import i2c_reg_sequencer_pkg::*;
#(
    parameter int MAX_LEN     = 16,
    parameter int LEN_W       = 5,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_rw,
    input  logic [6:0]       req_dev,
    input  logic [7:0]       req_reg,
    input  logic [7:0]       req_wdata,
    input  logic [LEN_W-1:0] req_len,
    output logic             rd_valid,
    output logic [7:0]       rd_data,
    output logic             rd_last,
    output logic             resp_done,
    output logic [1:0]       resp_err,
    input  logic             tick,
    output logic             m_start,
    output logic             m_stop,
    output logic             m_write,
    output logic             m_read,
    output logic             m_ack_in,
    output logic [7:0]       m_data_in,
    input  logic [7:0]       m_data_out,
    input  logic             m_done,
    input  logic             m_busy,
    input  logic             m_ack_err
);

    state_t state, state_nxt;
    phase_t phase, phase_nxt;

    logic             rw_q;
    logic [6:0]       dev_q;
    logic [7:0]       reg_q;
    logic [7:0]       wdata_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt_q;
    logic [1:0]       err_q, err_nxt;

    logic accept;
    logic len_bad;
    logic last_byte;
    logic rbyte_done;
    logic hold_done;
    logic relatch_fire;
    logic cmd_load;
    logic relatch_load;
    logic timeout_hit;
    cmd_t cmd_set;

    // The master's busy flag is informational; sequencing relies on m_done alone
    logic unused_inputs;
    assign unused_inputs = m_busy;

    assign accept     = req_valid && (state == ST_IDLE);
    assign len_bad    = (req_len == '0) || (req_len > LEN_W'(MAX_LEN));
    assign last_byte  = (cnt_q == len_q - 1'b1);
    assign rbyte_done = (state == ST_RBYTE) && (phase == PH_WAIT) && m_done && !timeout_hit;

`ifdef I2C_SEQ_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] to_cnt;

    // Restarted on every command load, so each byte gets its own full budget
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt <= '0;
        end else if (phase == PH_LOAD) begin
            to_cnt <= '0;
        end else if (!timeout_hit) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    assign timeout_hit = is_bus_state(state) && (phase != PH_LOAD) &&
                         (to_cnt == TO_W'(TIMEOUT_CYC - 1));
`else
    localparam int UNUSED_TIMEOUT_CYC = TIMEOUT_CYC;

    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            phase <= PH_LOAD;
        end else begin
            state <= state_nxt;
            phase <= phase_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        phase_nxt = phase;
        err_nxt   = err_q;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    phase_nxt = PH_LOAD;
                    if ((req_rw == RW_READ) && len_bad) begin
                        state_nxt = ST_DONE;
                        err_nxt   = ERR_LEN;
                    end else begin
                        state_nxt = ST_A_W;
                        err_nxt   = ERR_OK;
                    end
                end
            end
            ST_RELATCH: begin
                if (phase == PH_LOAD) begin
                    phase_nxt = PH_HOLD;
                end else if (relatch_fire) begin
                    state_nxt = ST_RBYTE;
                    phase_nxt = PH_LOAD;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                case (phase)
                    PH_LOAD: phase_nxt = PH_HOLD;
                    PH_HOLD: if (hold_done) phase_nxt = PH_WAIT;
                    default: begin
                        if (m_done) begin
                            phase_nxt = PH_LOAD;
                            // A NACKed address/data byte makes the master stop the bus on its own
                            if (m_ack_err && (state != ST_RBYTE) && (state != ST_STOP)) begin
                                state_nxt = ST_DONE;
                                err_nxt   = ERR_NACK;
                            end else begin
                                case (state)
                                    ST_A_W:   state_nxt = ST_REG;
                                    ST_REG:   state_nxt = (rw_q == RW_WRITE) ? ST_WDATA : ST_RS;
                                    ST_WDATA: state_nxt = ST_STOP;
                                    ST_RS:    state_nxt = ST_RELATCH;
                                    ST_RBYTE: if (last_byte) state_nxt = ST_DONE;
                                    default:  state_nxt = ST_DONE;
                                endcase
                            end
                        end
                    end
                endcase
                if (timeout_hit) begin
                    state_nxt = ST_DONE;
                    phase_nxt = PH_LOAD;
                    err_nxt   = ERR_TIMEOUT;
                end
            end
        endcase
    end

    always_comb begin
        cmd_load     = 1'b0;
        relatch_load = 1'b0;
        cmd_set      = CMD_NONE;
        if (phase == PH_LOAD) begin
            case (state)
                ST_A_W: begin
                    cmd_load      = 1'b1;
                    cmd_set.start = 1'b1;
                    cmd_set.write = 1'b1;
                    cmd_set.data  = {dev_q, RW_WRITE};
                end
                ST_REG: begin
                    cmd_load      = 1'b1;
                    cmd_set.write = 1'b1;
                    cmd_set.data  = reg_q;
                end
                ST_WDATA: begin
                    cmd_load      = 1'b1;
                    cmd_set.write = 1'b1;
                    cmd_set.data  = wdata_q;
                end
                ST_RS: begin
                    cmd_load      = 1'b1;
                    cmd_set.start = 1'b1;
                    cmd_set.write = 1'b1;
                    cmd_set.data  = {dev_q, RW_READ};
                end
                ST_RELATCH: begin
                    relatch_load = 1'b1;
                end
                ST_RBYTE: begin
                    cmd_load       = 1'b1;
                    cmd_set.read   = 1'b1;
                    cmd_set.ack_in = last_byte;
                end
                ST_STOP: begin
                    cmd_load     = 1'b1;
                    cmd_set.stop = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign req_ready = (state == ST_IDLE);
    assign resp_done = (state == ST_DONE);
    assign resp_err  = resp_done ? err_q : ERR_OK;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rw_q     <= RW_WRITE;
            dev_q    <= '0;
            reg_q    <= '0;
            wdata_q  <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            err_q    <= ERR_OK;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            rd_data  <= '0;
        end else begin
            err_q    <= err_nxt;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            if (accept) begin
                rw_q    <= req_rw;
                dev_q   <= req_dev;
                reg_q   <= req_reg;
                wdata_q <= req_wdata;
                len_q   <= req_len;
                cnt_q   <= '0;
            end
            if (rbyte_done) begin
                rd_valid <= 1'b1;
                rd_data  <= m_data_out;
                rd_last  <= last_byte;
                cnt_q    <= cnt_q + 1'b1;
            end
        end
    end

    i2c_cmd_hold u_cmd_hold (
        .clk          (clk),
        .reset_n      (reset_n),
        .tick         (tick),
        .load         (cmd_load),
        .cmd_set      (cmd_set),
        .relatch_load (relatch_load),
        .clear        (timeout_hit),
        .hold_done    (hold_done),
        .relatch_fire (relatch_fire),
        .m_start      (m_start),
        .m_stop       (m_stop),
        .m_write      (m_write),
        .m_read       (m_read),
        .m_ack_in     (m_ack_in),
        .m_data_in    (m_data_in)
    );

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Self-checking bench for i2c_reg_sequencer: a byte-level master responder plus a transaction-level
// reference of the expected bus command sequence, read data and response code.
`timescale 1ns/1ps
module tb_i2c_reg_sequencer;

    localparam int MAX_LEN = 16;
    localparam int LEN_W   = 5;
    localparam int TO_CYC  = 300;
    localparam logic [13:0] RELATCH_EV = 14'h2000;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             req_valid;
    logic             req_ready;
    logic             req_rw;
    logic [6:0]       req_dev;
    logic [7:0]       req_reg;
    logic [7:0]       req_wdata;
    logic [LEN_W-1:0] req_len;
    logic             rd_valid;
    logic [7:0]       rd_data;
    logic             rd_last;
    logic             resp_done;
    logic [1:0]       resp_err;
    logic             tick;
    logic             m_start, m_stop, m_write, m_read, m_ack_in;
    logic [7:0]       m_data_in;
    logic [7:0]       m_data_out;
    logic             m_done, m_busy, m_ack_err;

    int n_checks = 0;
    int n_errs   = 0;

    // Bus events seen by the master responder: {relatch, start, stop, write, read, ack_in, data}
    logic [13:0] ev_q[$];
    logic [7:0]  sup_q[$];
    int          wr_events = 0;
    int          nack_ev   = -1;
    bit          withhold  = 1'b0;

    logic [7:0] rd_q[$];
    bit         last_q[$];
    int         cyc       = 0;
    int         done_cnt  = 0;
    int         done_cyc  = 0;
    int         start_cnt = 0;
    int         err_seen  = 0;

    i2c_reg_sequencer #(
        .MAX_LEN     (MAX_LEN),
        .LEN_W       (LEN_W),
        .TIMEOUT_CYC (TO_CYC)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_rw     (req_rw),
        .req_dev    (req_dev),
        .req_reg    (req_reg),
        .req_wdata  (req_wdata),
        .req_len    (req_len),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .rd_last    (rd_last),
        .resp_done  (resp_done),
        .resp_err   (resp_err),
        .tick       (tick),
        .m_start    (m_start),
        .m_stop     (m_stop),
        .m_write    (m_write),
        .m_read     (m_read),
        .m_ack_in   (m_ack_in),
        .m_data_in  (m_data_in),
        .m_data_out (m_data_out),
        .m_done     (m_done),
        .m_busy     (m_busy),
        .m_ack_err  (m_ack_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [13:0] ev_enc(input bit s, input bit p, input bit w, input bit r,
                                           input bit a, input logic [7:0] d);
        return {1'b0, s, p, w, r, a, d};
    endfunction

    // Bit-phase tick: one cycle high out of every four
    initial begin
        tick = 1'b0;
        forever begin
            repeat (3) @(posedge clk);
            #1 tick = 1'b1;
            @(posedge clk);
            #1 tick = 1'b0;
        end
    end

    // Byte-level master responder: takes a command on a tick cycle, answers with m_done later
    initial begin
        int          pend;
        bit          pend_nack;
        logic [7:0]  b;
        pend       = 0;
        pend_nack  = 1'b0;
        m_done     = 1'b0;
        m_ack_err  = 1'b0;
        m_data_out = 8'h00;
        m_busy     = 1'b0;
        forever begin
            @(negedge clk);
            m_done    = 1'b0;
            m_ack_err = 1'b0;
            if (!reset_n) begin
                pend   = 0;
                m_busy = 1'b0;
            end else begin
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        m_done    = 1'b1;
                        m_ack_err = pend_nack;
                        m_busy    = 1'b0;
                    end
                end
                if (tick && (m_start || m_stop || m_write || m_read)) begin
                    ev_q.push_back(ev_enc(m_start, m_stop, m_write, m_read, m_ack_in, m_data_in));
                    pend_nack = (wr_events == nack_ev);
                    if (m_read) begin
                        b = 8'($urandom);
                        m_data_out = b;
                        sup_q.push_back(b);
                    end
                    wr_events++;
                    m_busy = 1'b1;
                    if (!withhold) pend = int'($urandom_range(6, 1));
                end else if (!tick && m_start && m_read && !m_write) begin
                    ev_q.push_back(RELATCH_EV);
                end
            end
        end
    end

    // Output monitor
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rd_valid) begin
                rd_q.push_back(rd_data);
                last_q.push_back(rd_last);
            end
            if (resp_done) begin
                done_cnt++;
                done_cyc = cyc;
                err_seen = int'(resp_err);
            end
            if (m_start) start_cnt++;
        end
    end

    task automatic pulse_reset();
        @(negedge clk); #1;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic issue(input bit rw, input logic [6:0] dev, input logic [7:0] rg,
                         input logic [7:0] wd, input int len, output int t0);
        @(negedge clk); #1;
        req_rw    = rw;
        req_dev   = dev;
        req_reg   = rg;
        req_wdata = wd;
        req_len   = LEN_W'(len);
        req_valid = 1'b1;
        t0 = cyc;
        @(negedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic run_txn(input bit rw, input logic [6:0] dev, input logic [7:0] rg,
                           input logic [7:0] wd, input int len, input int nack_at, input bit poke);
        logic [13:0] exp_ev[$];
        logic [13:0] obs;
        int exp_err, n_rd_exp, waited, t0, n_ev, n_rd;
        int ev_base, rd_base, sup_base, done_base, start_base;
        bit bad;
        bad = rw && (len == 0 || len > MAX_LEN);
        exp_ev = {};
        n_rd_exp = 0;
        if (bad) begin
            exp_err = 2;
        end else begin
            exp_ev.push_back(ev_enc(1, 0, 1, 0, 0, {dev, 1'b0}));
            exp_ev.push_back(ev_enc(0, 0, 1, 0, 0, rg));
            if (!rw) begin
                exp_ev.push_back(ev_enc(0, 0, 1, 0, 0, wd));
                exp_ev.push_back(ev_enc(0, 1, 0, 0, 0, 8'h00));
            end else begin
                exp_ev.push_back(ev_enc(1, 0, 1, 0, 0, {dev, 1'b1}));
                exp_ev.push_back(RELATCH_EV);
                for (int i = 0; i < len; i++) exp_ev.push_back(ev_enc(0, 0, 0, 1, i == len - 1, 8'h00));
            end
            if (nack_at >= 0) begin
                exp_ev  = exp_ev[0:nack_at];
                exp_err = 1;
            end else begin
                exp_err  = 0;
                n_rd_exp = rw ? len : 0;
            end
        end

        ev_base    = ev_q.size();
        rd_base    = rd_q.size();
        sup_base   = sup_q.size();
        done_base  = done_cnt;
        start_base = start_cnt;
        nack_ev    = (nack_at >= 0 && !bad) ? wr_events + nack_at : -1;

        issue(rw, dev, rg, wd, len, t0);
        waited = 0;
        while (done_cnt == done_base && waited < 3000) begin
            @(negedge clk); #1;
            waited++;
            // A request while busy must be dropped, not queued
            req_valid = poke && !bad && (nack_at < 0) && (waited == 8);
        end
        req_valid = 1'b0;
        repeat (25) @(negedge clk);
        #1;

        check("done_cnt", done_cnt - done_base, 1);
        check("resp_err", err_seen, exp_err);
        if (bad) begin
            check("len_latency_ok", int'((done_cyc - t0) <= 2), 1);
            check("len_no_start", start_cnt - start_base, 0);
        end
        n_ev = ev_q.size() - ev_base;
        check("bus_ev_count", n_ev, exp_ev.size());
        for (int i = 0; i < n_ev && i < exp_ev.size(); i++) begin
            obs = ev_q[ev_base + i];
            if (!exp_ev[i][10]) obs[7:0] = 8'h00;
            check($sformatf("bus_ev%0d", i), int'(obs), int'(exp_ev[i]));
        end
        n_rd = rd_q.size() - rd_base;
        check("rd_count", n_rd, n_rd_exp);
        for (int i = 0; i < n_rd && i < n_rd_exp; i++) begin
            check($sformatf("rd_data%0d", i), int'(rd_q[rd_base + i]), int'(sup_q[sup_base + i]));
            check($sformatf("rd_last%0d", i), int'(last_q[rd_base + i]), int'(i == n_rd_exp - 1));
        end
        check("req_ready_after", int'(req_ready), 1);
        nack_ev = -1;
        if (waited >= 3000) pulse_reset();
    endtask

    task automatic check_reset_outputs(input string tag);
        check(tag, int'({req_ready, resp_done, resp_err, rd_valid, rd_last, rd_data,
                         m_start, m_stop, m_write, m_read, m_ack_in, m_data_in}),
              int'({1'b1, 26'd0}));
    endtask

    task automatic run_timeout();
        int t0, done_base, waited, lat;
        done_base = done_cnt;
        withhold  = 1'b1;
        issue(1'b0, 7'h21, 8'h44, 8'h99, 1, t0);
        waited = 0;
        while (done_cnt == done_base && waited < TO_CYC + 100) begin
            @(negedge clk); #1;
            waited++;
        end
`ifdef I2C_SEQ_TIMEOUT_EN
        lat = done_cyc - t0;
        check("to_done_cnt", done_cnt - done_base, 1);
        check("to_err", err_seen, 3);
        check("to_latency_ok", int'(lat >= TO_CYC && lat <= TO_CYC + 4), 1);
        repeat (3) @(negedge clk);
        #1;
        check("to_ready_after", int'(req_ready), 1);
        check("to_cmd_cleared", int'({m_start, m_stop, m_write, m_read}), 0);
        withhold = 1'b0;
`else
        lat = waited;
        check("to_still_waiting", done_cnt - done_base, 0);
        check("to_not_ready", int'(req_ready), 0);
        withhold = 1'b0;
        pulse_reset();
        check("to_ready_after_reset", int'(req_ready), 1);
`endif
    endtask

    initial begin
        int t0, rd_base, waited, len, nack_at;
        bit rw;
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_rw    = 1'b0;
        req_dev   = '0;
        req_reg   = '0;
        req_wdata = '0;
        req_len   = '0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset_state");
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        run_txn(1'b0, 7'h53, 8'h2D, 8'h08, 1, -1, 1'b1);
        run_txn(1'b1, 7'h53, 8'h32, 8'h00, 6, -1, 1'b1);
        run_txn(1'b0, 7'h53, 8'h10, 8'h55, 1, 0, 1'b0);
        run_txn(1'b1, 7'h2A, 8'h07, 8'h00, 3, 2, 1'b0);
        run_txn(1'b0, 7'h0F, 8'hE1, 8'h3C, 1, 2, 1'b0);
        run_txn(1'b1, 7'h53, 8'h32, 8'h00, 0, -1, 1'b0);
        run_txn(1'b1, 7'h53, 8'h32, 8'h00, 17, -1, 1'b0);
        run_txn(1'b1, 7'h7F, 8'hFF, 8'h00, 16, -1, 1'b0);
        run_txn(1'b1, 7'h00, 8'h00, 8'h00, 1, -1, 1'b0);

        run_timeout();

        // Reset in the middle of a burst read, then a clean transaction
        rd_base = rd_q.size();
        issue(1'b1, 7'h53, 8'h32, 8'h00, 4, t0);
        waited = 0;
        while (rd_q.size() == rd_base && waited < 2000) begin
            @(negedge clk); #1;
            waited++;
        end
        reset_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset_state");
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b1;
        run_txn(1'b1, 7'h1E, 8'h05, 8'h00, 2, -1, 1'b0);

        for (int k = 0; k < 10; k++) begin
            rw      = 1'($urandom);
            len     = int'($urandom_range(18, 0));
            nack_at = ($urandom_range(4, 0) == 0) ? int'($urandom_range(2, 0)) : -1;
            run_txn(rw, 7'($urandom), 8'($urandom), 8'($urandom), len, nack_at, 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
